// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply (LSB first) and restoring
// division (MSB first) on operand magnitudes, with sign fix-up in a final
// cycle. HI/LO are only committed when an operation completes, so an abort
// or an explicit HI/LO write mid-operation never leaves them half-updated.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             abort_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned RW = WIDTH + 1;  // partial remainder width
  localparam int unsigned SW = WIDTH + 2;  // shifted remainder incl. headroom bit

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   prod_q, prod_d;   // {partial product, remaining multiplier}
  logic [W-1:0]     mcand_q, mcand_d; // |multiplicand|
  logic [W-1:0]     quot_q, quot_d;   // dividend bits shift out, quotient bits shift in
  logic [RW-1:0]    rem_q, rem_d;
  logic [W-1:0]     dvsr_q, dvsr_d;   // |divisor|
  logic [W-1:0]     op1_q, op1_d;     // raw dividend, needed for the div-by-zero result
  logic             is_div_q, is_div_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div0_q, div0_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand capture: magnitudes and result signs for the signed ops.
  logic             cap_signed;
  logic [W-1:0]     cap_mag1, cap_mag2;

  always_comb begin
    cap_signed = ~op_i[0];
    cap_mag1   = (cap_signed && op1_i[W-1]) ? (~op1_i + 1'b1) : op1_i;
    cap_mag2   = (cap_signed && op2_i[W-1]) ? (~op2_i + 1'b1) : op2_i;
  end

  // One shift-add multiply step: add multiplicand if the current multiplier bit is set.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, prod_q[W-1:1]};
  end

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  logic [SW-1:0] div_shift;
  logic          div_ge;
  logic [RW-1:0] rem_next;
  logic [W-1:0]  quot_next;

  always_comb begin
    div_shift = {rem_q, quot_q[W-1]};
    div_ge    = (div_shift >= SW'(dvsr_q));
    rem_next  = div_ge ? RW'(div_shift - SW'(dvsr_q)) : div_shift[RW-1:0];
    quot_next = {quot_q[W-2:0], div_ge};
  end

  // Final sign fix-up and result selection for the commit cycle.
  logic [2*W-1:0] fix_prod;
  logic [W-1:0]   fix_quot, fix_rem;
  logic [W-1:0]   fix_hi, fix_lo;

  always_comb begin
    fix_prod = q_neg_q ? (~prod_q + 1'b1) : prod_q;
    fix_quot = q_neg_q ? (~quot_q + 1'b1) : quot_q;
    // Remainder is always < divisor, so the top bit of the W+1-bit remainder is zero here.
    fix_rem  = r_neg_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
    if (!is_div_q) begin
      fix_hi = fix_prod[2*W-1:W];
      fix_lo = fix_prod[W-1:0];
    end else if (div0_q) begin
      fix_hi = op1_q;
      fix_lo = '1;
    end else begin
      fix_hi = fix_rem;
      fix_lo = fix_quot;
    end
  end

  // Next-state logic: FSM sequencing, iteration, commit and explicit HI/LO writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    op1_d    = op1_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort in the same cycle drops the request
        if (go_i && !abort_i) begin
          state_d  = StRun;
          cnt_d    = '0;
          prod_d   = {{W{1'b0}}, cap_mag2};
          mcand_d  = cap_mag1;
          quot_d   = cap_mag1;
          rem_d    = '0;
          dvsr_d   = cap_mag2;
          op1_d    = op1_i;
          is_div_d = op_i[1];
          q_neg_d  = cap_signed & (op1_i[W-1] ^ op2_i[W-1]);
          r_neg_d  = cap_signed & op1_i[W-1];
          div0_d   = (op2_i == '0);
        end
      end
      StRun: begin
        // An explicit HI/LO write supersedes the in-flight result.
        if (abort_i || wr_hi_i || wr_lo_i) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            rem_d  = rem_next;
            quot_d = quot_next;
          end else begin
            prod_d = mul_next;
          end
          if (cnt_q == LastIter) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!abort_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Explicit writes win over a same-cycle commit for the register they target.
    if (wr_hi_i) begin
      hi_d = wr_val_i;
    end
    if (wr_lo_i) begin
      lo_d = wr_val_i;
    end

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      op1_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      op1_q    <= op1_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and go cycle are queued at
// issue time and compared, together with the result latency, on each done pulse.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int          Lat = W + 1;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         go     = 1'b0;
  logic         abort  = 1'b0;
  logic         wr_hi  = 1'b0;
  logic         wr_lo  = 1'b0;
  logic [1:0]   op     = '0;
  logic [W-1:0] op1    = '0;
  logic [W-1:0] op2    = '0;
  logic [W-1:0] wr_val = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           go_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .go_i    (go),
    .op_i    (op),
    .op1_i   (op1),
    .op2_i   (op2),
    .abort_i (abort),
    .wr_hi_i (wr_hi),
    .wr_lo_i (wr_lo),
    .wr_val_i(wr_val),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("hi", 64'(hi), 64'(e.hi));
        check_eq("lo", 64'(lo), 64'(e.lo));
        check_eq("latency", 64'(cyc - e.go_cyc), 64'(Lat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model returning {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [63:0] r;
    longint      sa, sbv;
    int          q, m;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (o)
      2'd0: r = sa * sbv;
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
      default: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [63:0] e);
    exp_t x;
    op  = o;
    op1 = a;
    op2 = b;
    go  = 1'b1;
    tick();
    go  = 1'b0;
    if (push) begin
      x.hi     = e[63:32];
      x.lo     = e[31:0];
      x.go_cyc = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic mt(input logic sel_hi, input logic [W-1:0] v);
    wr_val = v;
    if (sel_hi) wr_hi = 1'b1;
    else wr_lo = 1'b1;
    tick();
    wr_hi = 1'b0;
    wr_lo = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int            base;
    logic [1:0]    ro;
    logic [W-1:0]  ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    issue(2'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
    drain();
    issue(2'd1, 32'hFFFF_FFFF, 32'd7, 1'b1, 64'h0000_0006_FFFF_FFF9);
    drain();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    drain();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    drain();
    issue(2'd3, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E);
    drain();
    issue(2'd3, 32'h64, 32'd0, 1'b1, 64'h0000_0064_FFFF_FFFF);
    drain();
    issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b1, 64'hFFFF_FFF0_FFFF_FFFF);
    drain();

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) ra = -ra;
      issue(ro, ra, rb, 1'b1, model(ro, ra, rb));
      drain();
    end

    // go while busy is ignored
    issue(2'd0, 32'd3, 32'd5, 1'b1, 64'd15);
    repeat (5) tick();
    issue(2'd1, 32'd1000, 32'd1000, 1'b0, 64'd0);
    drain();

    // Back-to-back: second go in the done cycle
    issue(2'd1, 32'd9, 32'd11, 1'b1, 64'd99);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      tick();
    end
    check_eq("b2b_done_seen", 64'(done), 64'd1);
    issue(2'd3, 32'd50, 32'd6, 1'b1, 64'h0000_0002_0000_0008);
    drain();

    // abort and go in the same idle cycle: go dropped
    abort = 1'b1;
    issue(2'd0, 32'd2, 32'd2, 1'b0, 64'd0);
    abort = 1'b0;
    check_eq("abort_go_busy", 64'(busy), 64'd0);

    // Abort on cycle 10
    mt(1'b0, 32'h1234);
    mt(1'b1, 32'h5678);
    check_eq("mt_hi", 64'(hi), 64'h5678);
    check_eq("mt_lo", 64'(lo), 64'h1234);
    base = done_cnt;
    issue(2'd0, 32'd3, 32'd5, 1'b0, 64'd0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check_eq("abort_no_done", 64'(done_cnt), 64'(base));
    check_eq("abort_hi", 64'(hi), 64'h5678);
    check_eq("abort_lo", 64'(lo), 64'h1234);

    // MTLO at cycle 5 cancels the operation
    issue(2'd0, 32'd3, 32'd5, 1'b0, 64'd0);
    repeat (4) tick();
    wr_val = 32'hAA;
    wr_lo  = 1'b1;
    tick();
    wr_lo  = 1'b0;
    check_eq("wrlo_busy", 64'(busy), 64'd0);
    check_eq("wrlo_lo", 64'(lo), 64'hAA);
    check_eq("wrlo_hi", 64'(hi), 64'h5678);
    repeat (40) tick();
    check_eq("wrlo_no_done", 64'(done_cnt), 64'(base));

    // MTHI in the FIX cycle: HI takes the write, LO the result, done still pulses
    issue(2'd1, 32'd2, 32'd3, 1'b1, 64'h0000_BEEF_0000_0006);
    repeat (Lat - 1) tick();
    wr_val = 32'hBEEF;
    wr_hi  = 1'b1;
    tick();
    wr_hi  = 1'b0;
    drain();

    // Reset in the middle of a DIV
    issue(2'd2, 32'd100, 32'd7, 1'b0, 64'd0);
    repeat (14) tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    issue(2'd1, 32'd2, 32'd3, 1'b1, 64'd6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
